// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for the hazard unit: stage-tagged control inputs from the
// pipelined control block, and the stall/flush/forward/counter outputs sent back to it.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      i_instD;
    logic             i_lsu_rdenE;
    logic             i_rd_wrenM;
    logic             i_rd_wrenW;
    logic             i_jalE;
    logic             i_branchE;
    logic             i_br_takenE;
    logic             o_stall;
    logic             o_flushD;
    logic             o_flushE;
    logic [1:0]       o_fwd_aE;
    logic [1:0]       o_fwd_bE;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    // Pipeline / control-block side.
    modport master (
        output i_instD, i_lsu_rdenE, i_rd_wrenM, i_rd_wrenW, i_jalE, i_branchE, i_br_takenE,
        input  o_stall, o_flushD, o_flushE, o_fwd_aE, o_fwd_bE, o_stall_cnt, o_flush_cnt
    );

    // Hazard unit side.
    modport slave (
        input  i_instD, i_lsu_rdenE, i_rd_wrenM, i_rd_wrenW, i_jalE, i_branchE, i_br_takenE,
        output o_stall, o_flushD, o_flushE, o_fwd_aE, o_fwd_bE, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I core: load-use stall, redirect flush, EX-stage
// operand forwarding from a shadow pipeline of register addresses, plus saturating counters.
module hazard_unit #(
    parameter int unsigned CNT_W = 32
) (
    input logic         i_clk,
    input logic         i_rst,
    hazard_unit_if.slave hz
);

    localparam logic [1:0] FwdRf = 2'b00;
    localparam logic [1:0] FwdM  = 2'b01;
    localparam logic [1:0] FwdW  = 2'b10;

    logic [4:0] rs1D, rs2D, rdD;
    logic [4:0] rs1E_q, rs1E_d;
    logic [4:0] rs2E_q, rs2E_d;
    logic [4:0] rdE_q, rdE_d;
    logic [4:0] rdM_q, rdM_d;
    logic [4:0] rdW_q, rdW_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic redirect;
    logic load_use;
    logic stall;
    logic flush;
    logic [1:0] fwd_a, fwd_b;

    // Opcode/funct bits are deliberately ignored; field decoding is unqualified.
    logic unused_instd;
    assign unused_instd = ^{hz.i_instD[31:25], hz.i_instD[14:12], hz.i_instD[6:0]};

    assign rs1D = hz.i_instD[19:15];
    assign rs2D = hz.i_instD[24:20];
    assign rdD  = hz.i_instD[11:7];

    // Youngest producer (M) wins over W; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       wren_m,
                                           input logic [4:0] rd_m,
                                           input logic       wren_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = FwdRf;
        if (wren_m && (rd_m != 5'd0) && (rd_m == src)) begin
            sel = FwdM;
        end else if (wren_w && (rd_w != 5'd0) && (rd_w == src)) begin
            sel = FwdW;
        end
        return sel;
    endfunction

    always_comb begin
        redirect = hz.i_jalE | (hz.i_branchE & hz.i_br_takenE);
        load_use = hz.i_lsu_rdenE & (rdE_q != 5'd0) & ((rdE_q == rs1D) | (rdE_q == rs2D));

        // Redirect beats load-use: the stalled D instruction is being flushed anyway.
        stall = ~i_rst & load_use & ~redirect;
        flush = ~i_rst & redirect;

        fwd_a = FwdRf;
        fwd_b = FwdRf;
        if (!i_rst) begin
            fwd_a = fwd_sel(rs1E_q, hz.i_rd_wrenM, rdM_q, hz.i_rd_wrenW, rdW_q);
            fwd_b = fwd_sel(rs2E_q, hz.i_rd_wrenM, rdM_q, hz.i_rd_wrenW, rdW_q);
        end
    end

    always_comb begin
        rs1E_d = rs1D;
        rs2E_d = rs2D;
        rdE_d  = rdD;
        if (flush || stall) begin
            rs1E_d = 5'd0;
            rs2E_d = 5'd0;
            rdE_d  = 5'd0;
        end
        rdM_d = rdE_q;
        rdW_d = rdM_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rs1E_q      <= 5'd0;
            rs2E_q      <= 5'd0;
            rdE_q       <= 5'd0;
            rdM_q       <= 5'd0;
            rdW_q       <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            rs1E_q      <= rs1E_d;
            rs2E_q      <= rs2E_d;
            rdE_q       <= rdE_d;
            rdM_q       <= rdM_d;
            rdW_q       <= rdW_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.o_stall     = stall;
    assign hz.o_flushD    = flush;
    assign hz.o_flushE    = flush;
    assign hz.o_fwd_aE    = fwd_a;
    assign hz.o_fwd_bE    = fwd_b;
    assign hz.o_stall_cnt = stall_cnt_q;
    assign hz.o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a stage-record model of the pipeline.
module tb_hazard_unit;

    localparam int unsigned CW  = 4;
    localparam int          MAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    hazard_unit_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: the register fields of the instruction in each stage, plus event counts.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
    } instr_t;

    instr_t st_e;
    int     rd_m, rd_w;
    int     n_stall, n_flush;

    function automatic logic [31:0] mk(input int rs2, input int rs1, input int rd);
        logic [31:0] w;
        w = 32'h0000_0033;
        w[24:20] = rs2[4:0];
        w[19:15] = rs1[4:0];
        w[11:7]  = rd[4:0];
        return w;
    endfunction

    function automatic int m_redirect();
        return (hz.i_jalE || (hz.i_branchE && hz.i_br_takenE)) ? 1 : 0;
    endfunction

    function automatic int m_stall();
        int rs1d, rs2d;
        rs1d = int'(hz.i_instD[19:15]);
        rs2d = int'(hz.i_instD[24:20]);
        if (rst || m_redirect() != 0) return 0;
        if (hz.i_lsu_rdenE && st_e.rd != 0 && (st_e.rd == rs1d || st_e.rd == rs2d)) return 1;
        return 0;
    endfunction

    function automatic int m_fwd(input int src);
        if (rst) return 0;
        if (hz.i_rd_wrenM && rd_m != 0 && rd_m == src) return 1;
        if (hz.i_rd_wrenW && rd_w != 0 && rd_w == src) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int fl;
        fl = rst ? 0 : m_redirect();
        chk("stall", int'(hz.o_stall), m_stall());
        chk("flushD", int'(hz.o_flushD), fl);
        chk("flushE", int'(hz.o_flushE), fl);
        chk("fwd_a", int'(hz.o_fwd_aE), m_fwd(st_e.rs1));
        chk("fwd_b", int'(hz.o_fwd_bE), m_fwd(st_e.rs2));
        chk("stall_cnt", int'(hz.o_stall_cnt), n_stall);
        chk("flush_cnt", int'(hz.o_flush_cnt), n_flush);
    endtask

    task automatic apply(input logic [31:0] inst, input logic lsu, input logic wm,
                         input logic ww, input logic jal, input logic br, input logic tk,
                         input logic r);
        hz.i_instD     = inst;
        hz.i_lsu_rdenE = lsu;
        hz.i_rd_wrenM  = wm;
        hz.i_rd_wrenW  = ww;
        hz.i_jalE      = jal;
        hz.i_branchE   = br;
        hz.i_br_takenE = tk;
        rst            = r;
        #3;
        check_model();
    endtask

    // Advance one edge, updating the model from the inputs held across it.
    task automatic tick();
        int st, fl;
        instr_t d;
        st = m_stall();
        fl = rst ? 0 : m_redirect();
        d.rs1 = int'(hz.i_instD[19:15]);
        d.rs2 = int'(hz.i_instD[24:20]);
        d.rd  = int'(hz.i_instD[11:7]);
        @(posedge clk);
        if (rst) begin
            st_e = '{0, 0, 0};
            rd_m = 0;
            rd_w = 0;
            n_stall = 0;
            n_flush = 0;
        end else begin
            rd_w = rd_m;
            rd_m = st_e.rd;
            st_e = (st != 0 || fl != 0) ? '{0, 0, 0} : d;
            if (st != 0 && n_stall < MAX) n_stall++;
            if (fl != 0 && n_flush < MAX) n_flush++;
        end
        #1;
    endtask

    initial begin
        st_e = '{0, 0, 0};
        rd_m = 0;
        rd_w = 0;
        n_stall = 0;
        n_flush = 0;

        // Reset: first edge brings state out of X before any comparison.
        hz.i_instD = '0; hz.i_lsu_rdenE = 0; hz.i_rd_wrenM = 0; hz.i_rd_wrenW = 0;
        hz.i_jalE = 0; hz.i_branchE = 0; hz.i_br_takenE = 0; rst = 1;
        tick();
        apply(mk(5, 5, 5), 1, 1, 1, 0, 0, 0, 1);
        chk("rst_stall_forced", int'(hz.o_stall), 0);
        tick();
        apply('0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_stall_cnt", int'(hz.o_stall_cnt), 0);
        chk("post_rst_fwd_a", int'(hz.o_fwd_aE), 0);

        // Load-use: lw x5 then add x6,x5,x7.
        apply(mk(0, 0, 5), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(7, 5, 6), 1, 0, 0, 0, 0, 0, 0);
        chk("lu_stall", int'(hz.o_stall), 1);
        tick();
        apply(mk(7, 5, 6), 0, 0, 0, 0, 0, 0, 0);
        chk("lu_bubble_nostall", int'(hz.o_stall), 0);
        chk("lu_stall_cnt", int'(hz.o_stall_cnt), 1);
        tick();
        apply(mk(0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        chk("lu_fwd_w", int'(hz.o_fwd_aE), 2);

        // Forward priority: rdM = rdW = 3, rs1E = rs2E = 3.
        apply(mk(0, 0, 3), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(0, 0, 3), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(3, 3, 0), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(0, 0, 0), 0, 1, 1, 0, 0, 0, 0);
        chk("prio_a_m", int'(hz.o_fwd_aE), 1);
        chk("prio_b_m", int'(hz.o_fwd_bE), 1);
        apply(mk(0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
        chk("prio_a_w", int'(hz.o_fwd_aE), 2);
        chk("prio_b_w", int'(hz.o_fwd_bE), 2);
        tick();
        apply(mk(0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(0, 0, 0), 0, 1, 1, 0, 0, 0, 0);
        chk("x0_no_fwd", int'(hz.o_fwd_aE), 0);

        // Redirect beats load-use.
        apply(mk(0, 0, 5), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(7, 5, 6), 1, 0, 0, 0, 1, 1, 0);
        chk("redir_stall", int'(hz.o_stall), 0);
        chk("redir_flushD", int'(hz.o_flushD), 1);
        chk("redir_flushE", int'(hz.o_flushE), 1);
        tick();
        apply(mk(7, 5, 6), 1, 0, 0, 0, 0, 0, 0);
        chk("redir_flush_cnt", int'(hz.o_flush_cnt), 1);
        chk("redir_stall_cnt", int'(hz.o_stall_cnt), 1);
        chk("redir_e_cleared", int'(hz.o_stall), 0);
        tick();

        // Not-taken branch, then JAL.
        apply(mk(0, 0, 0), 0, 0, 0, 0, 1, 0, 0);
        chk("nt_branch_noflush", int'(hz.o_flushD), 0);
        apply(mk(0, 0, 0), 0, 0, 0, 1, 0, 0, 0);
        chk("jal_flush", int'(hz.o_flushE), 1);
        tick();
        apply(mk(0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        chk("jal_flush_cnt", int'(hz.o_flush_cnt), 2);

        // Saturation: 20 load-use stalls alternate with bubbles.
        for (int i = 0; i < 40; i++) begin
            apply(mk(0, 5, 5), 1, 0, 0, 0, 0, 0, 0);
            tick();
        end
        apply(mk(0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        chk("stall_cnt_sat", int'(hz.o_stall_cnt), 15);

        // Reset mid-stall.
        apply(mk(0, 0, 5), 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply(mk(7, 5, 6), 1, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_stall", int'(hz.o_stall), 0);
        tick();
        apply(mk(7, 5, 6), 1, 1, 1, 0, 0, 0, 0);
        chk("rst_clr_stall_cnt", int'(hz.o_stall_cnt), 0);
        chk("rst_clr_flush_cnt", int'(hz.o_flush_cnt), 0);
        chk("rst_after_stall", int'(hz.o_stall), 0);
        chk("rst_after_fwd_b", int'(hz.o_fwd_bE), 0);
        tick();

        // Randomized traffic on a small register set so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] inst;
            inst = $urandom;
            inst[19:15] = 5'($urandom_range(0, 6));
            inst[24:20] = 5'($urandom_range(0, 6));
            inst[11:7]  = 5'($urandom_range(0, 6));
            apply(inst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It produces the stall and flush inputs that the pipelined control block consumes, and takes back that block's stage-tagged outputs (E/M/W write and load enables, jump/branch flags). It keeps its own shadow pipeline of register addresses (E/M/W) to detect load-use hazards, select EX-stage operand forwarding, and redirect on taken control transfers. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_W, 32, width of the stall and flush event counters (2..32).

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  synchronous reset, active-high
i_instD  in  32  instruction in Decode stage; fields: rs1=[19:15], rs2=[24:20], rd=[11:7]
i_lsu_rdenE  in  1  instruction in Execute is a load
i_rd_wrenM  in  1  instruction in Memory writes rd
i_rd_wrenW  in  1  instruction in Writeback writes rd
i_jalE  in  1  instruction in Execute is JAL/JALR
i_branchE  in  1  instruction in Execute is a conditional branch
i_br_takenE  in  1  branch comparator result for the Execute instruction
o_stall  out  1  hold PC and IF/ID register; drives control-block stall (bubble into E)
o_flushD  out  1  clear IF/ID register at next edge
o_flushE  out  1  clear ID/EX register at next edge; drives control-block flush
o_fwd_aE  out  2  operand A source: 00 regfile, 01 M-stage ALU result, 10 W-stage writeback data
o_fwd_bE  out  2  operand B source, same encoding as o_fwd_aE
o_stall_cnt  out  CNT_W  count of stall cycles, saturating
o_flush_cnt  out  CNT_W  count of redirect cycles, saturating

Behaviour:
- Shadow state, updated each clock edge:
  - rs1E, rs2E, rdE (5b each): cleared to 0 on reset, on o_flushE, or on o_stall (bubble). Otherwise loaded from the i_instD fields.
  - rdM <= rdE; rdW <= rdM every cycle (no enable).
- Redirect: redirect = i_jalE | (i_branchE & i_br_takenE). Combinational. o_flushD = o_flushE = redirect.
- Load-use: lu = i_lsu_rdenE & (rdE != 0) & (rdE == rs1D | rdE == rs2D). Field decoding is not qualified by opcode; false stalls (e.g. LUI) are accepted.
  - o_stall = lu & ~redirect. Redirect has priority because the stalled D instruction is being flushed anyway.
- Forwarding (combinational, per operand X in {rs1E, rs2E}):
  - If i_rd_wrenM & rdM != 0 & rdM == X, select 01.
  - Else if i_rd_wrenW & rdW != 0 & rdW == X, select 10.
  - Else select 00.
  - M has priority over W (youngest producer wins). x0 is never forwarded.
- Latency:
  - Stall, flush and forward outputs are same-cycle combinational from shadow state and inputs.
  - A load followed directly by a dependent instruction costs exactly 1 stall cycle. The next cycle selects forward 10 from W (load data is not forwarded from M).
- Counters:
  - o_stall_cnt += 1 in each cycle o_stall = 1.
  - o_flush_cnt += 1 in each cycle redirect = 1.
  - Both hold at 2^CNT_W - 1, with no wrap.
- Reset (i_rst = 1 at an edge):
  - All shadow registers and counters go to 0.
  - While i_rst is high, o_stall, o_flushD, o_flushE, o_fwd_aE and o_fwd_bE are forced to 0.
  - After reset, the cleared shadow state means no stall or forward can fire until real instructions propagate.
- Reset mid-stall: the stall drops in the reset cycle and the counter clears. No partial state is retained.
- Back-to-back redirects: each cycle flushes independently; the counter increments each cycle.

Test Plan:
- Load-use: E = lw x5 (rdE=5, i_lsu_rdenE=1), D = add x6,x5,x7 -> o_stall=1 for 1 cycle and o_stall_cnt=1. Next cycle rdE=0 (bubble) and o_stall=0. Following cycle the add is in E with rdW=5, i_rd_wrenW=1 -> o_fwd_aE=10.
- Forward priority: rdM=3 and rdW=3 with both wrens 1, rs1E=3, rs2E=3 -> o_fwd_aE=o_fwd_bE=01. Drop i_rd_wrenM -> both 10. rdM=rdW=0 with wrens 1, rs1E=0 -> 00.
- Redirect vs load-use: i_branchE=1, i_br_takenE=1 together with a load-use match -> o_stall=0, o_flushD=o_flushE=1, o_flush_cnt +1, o_stall_cnt unchanged. Next cycle rdE=rs1E=rs2E=0.
- Not-taken branch: i_branchE=1, i_br_takenE=0 -> no flush. i_jalE=1 alone -> flush for 1 cycle.
- Counter saturation with CNT_W=4: hold the load-use condition for 20 cycles -> o_stall_cnt stops at 15.
- Synchronous reset: assert i_rst during a stall -> outputs 0 in that cycle and counters read 0 after the edge. Deassert -> o_stall=0 and o_fwd_*=00 until new instructions arrive.
